// File: rtl/order_manager_pkg.sv
// Shared trade encodings, widths and FSM state type for the order manager.
// Pure declarations plus one arithmetic helper; no timing of its own.
// No flow control; consumers own all handshaking.
package order_manager_pkg;

    // Signal stream encodings from the crossover generator
    localparam logic [1:0] SIG_HOLD = 2'b00;
    localparam logic [1:0] SIG_BUY  = 2'b01;
    localparam logic [1:0] SIG_SELL = 2'b11;

    // Order side encodings toward the gateway
    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    // Datapath widths: Q16.16 price, signed position, share count, order counter
    localparam int PRICE_W   = 32;
    localparam int POS_W     = 17;
    localparam int QTY_W     = 16;
    localparam int ORD_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    // Magnitude of an 18-bit position delta, narrowed to a share count.
    // The lot-size bound keeps the delta within 2*32767, so nothing is lost.
    function automatic logic [QTY_W-1:0] abs_qty(input logic signed [POS_W:0] d);
        return QTY_W'(d[POS_W] ? -d : d);
    endfunction

endpackage

// File: rtl/order_manager_cooldown_timer.sv
// Down-counter that holds the order FSM idle for COOLDOWN cycles after a fill.
// done is combinational from the count; a load restarts the count next cycle.
// No backpressure; counts only while enabled and stops at zero.
module order_manager_cooldown_timer #(
    parameter int COOLDOWN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int CNT_W    = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    // Loading COOLDOWN-1 makes done rise in the last of COOLDOWN counting cycles
    localparam int LOAD_VAL = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;

    logic [CNT_W-1:0] cnt;

    // Reload on accept, otherwise count down toward zero while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LOAD_VAL);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/order_manager.sv
// Turns a BUY/SELL/HOLD stream into market orders that move position between 0 and +/-LOT_QTY.
// Latency: a differing BUY/SELL beat in IDLE offers an order the next cycle.
// Backpressure: the offered order is held stable until ord_ready; later beats only retarget.
module order_manager
    import order_manager_pkg::*;
#(
    parameter int LOT_QTY  = 100,
    parameter int COOLDOWN = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [1:0]                in_signal,
    input  logic [PRICE_W-1:0]        in_price,
    output logic                      ord_valid,
    input  logic                      ord_ready,
    output logic                      ord_side,
    output logic [QTY_W-1:0]          ord_qty,
    output logic [PRICE_W-1:0]        ord_price,
    output logic signed [POS_W-1:0]   position,
    output logic [ORD_CNT_W-1:0]      orders_sent,
    output logic                      busy
);

    localparam logic signed [POS_W-1:0] LOT_LONG  = POS_W'(LOT_QTY);
    localparam logic signed [POS_W-1:0] LOT_SHORT = POS_W'(-LOT_QTY);

    state_t                     state;
    state_t                     state_nxt;
    logic signed [POS_W-1:0]    tgt_r;
    logic [PRICE_W-1:0]         price_r;

    logic                       beat;
    logic signed [POS_W-1:0]    dec_tgt;
    logic signed [POS_W-1:0]    eff_tgt;
    logic [PRICE_W-1:0]         eff_price;
    logic signed [POS_W:0]      tgt_delta;
    logic                       start_ord;
    logic                       accept;
    logic                       tmr_done;

    // Decode the incoming beat; only a qualified BUY/SELL moves the target
    always_comb begin
        beat    = 1'b0;
        dec_tgt = tgt_r;
        case (in_signal)
            SIG_BUY: begin
                beat    = in_valid;
                dec_tgt = LOT_LONG;
            end
            SIG_SELL: begin
                beat    = in_valid;
                dec_tgt = LOT_SHORT;
            end
            SIG_HOLD: begin
                beat    = 1'b0;
            end
            default: begin
                beat    = 1'b0;
            end
        endcase
    end

    // A same-cycle beat bypasses the target/price registers so IDLE reacts in one cycle
    always_comb begin
        eff_tgt   = beat ? dec_tgt : tgt_r;
        eff_price = beat ? in_price : price_r;
        tgt_delta = {eff_tgt[POS_W-1], eff_tgt} - {position[POS_W-1], position};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: launch on target mismatch, hold until accepted, then cool down
    always_comb begin
        state_nxt = state;
        start_ord = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eff_tgt != position) begin
                    start_ord = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ord_ready) begin
                    accept    = 1'b1;
                    state_nxt = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
                end
            end
            ST_COOL: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ord_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);

    // Target/price tracking, order capture on launch, position and count commit on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r       <= '0;
            price_r     <= '0;
            ord_side    <= SIDE_BUY;
            ord_qty     <= '0;
            ord_price   <= '0;
            position    <= '0;
            orders_sent <= '0;
        end else begin
            if (beat) begin
                tgt_r   <= dec_tgt;
                price_r <= in_price;
            end
            if (start_ord) begin
                ord_side  <= (eff_tgt < position) ? SIDE_SELL : SIDE_BUY;
                ord_qty   <= abs_qty(tgt_delta);
                ord_price <= eff_price;
            end
            if (accept) begin
                position    <= (ord_side == SIDE_SELL) ? position - $signed({1'b0, ord_qty})
                                                       : position + $signed({1'b0, ord_qty});
                orders_sent <= orders_sent + ORD_CNT_W'(1);
            end
        end
    end

    order_manager_cooldown_timer #(
        .COOLDOWN (COOLDOWN)
    ) u_cooldown (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .count (state == ST_COOL),
        .done  (tmr_done)
    );

endmodule

// File: tb/tb_order_manager.sv
// Drives two order managers (cooldown 16 and 0) with the same stimulus and scoreboards
// every cycle against a timestamp-based reference model of the trading rules.
module tb_order_manager;

    localparam int LOT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_signal = 2'b00;
    logic [31:0] in_price = 32'h0;
    logic        ord_ready = 1'b0;

    logic        ov   [2];
    logic        os   [2];
    logic [15:0] oq   [2];
    logic [31:0] op   [2];
    logic [16:0] pos  [2];
    logic [15:0] sent [2];
    logic        bsy  [2];

    always #5 clk = ~clk;

    order_manager #(.LOT_QTY(LOT), .COOLDOWN(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_signal(in_signal), .in_price(in_price),
        .ord_valid(ov[0]), .ord_ready(ord_ready), .ord_side(os[0]), .ord_qty(oq[0]),
        .ord_price(op[0]), .position(pos[0]), .orders_sent(sent[0]), .busy(bsy[0])
    );

    order_manager #(.LOT_QTY(LOT), .COOLDOWN(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_signal(in_signal), .in_price(in_price),
        .ord_valid(ov[1]), .ord_ready(ord_ready), .ord_side(os[1]), .ord_qty(oq[1]),
        .ord_price(op[1]), .position(pos[1]), .orders_sent(sent[1]), .busy(bsy[1])
    );

    typedef struct {
        int          cyc;
        logic        v;
        logic        side;
        logic [15:0] qty;
        logic [31:0] price;
        logic [16:0] pos;
        logic [15:0] sent;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: trading state plus the cycle from which a new order may be considered
    int          cd       [2] = '{16, 0};
    int          m_tgt    [2];
    int          m_pos    [2];
    int          m_sent   [2];
    int          free_at  [2];
    logic [31:0] m_price  [2];
    bit          offering [2];
    bit          o_side   [2];
    int          o_qty    [2];
    logic [31:0] o_price  [2];
    int          cyc = 0;
    bit          started = 1'b0;

    function automatic exp_t snapshot(input int k);
        exp_t e;
        e.cyc   = cyc;
        e.v     = offering[k];
        e.side  = o_side[k];
        e.qty   = 16'(o_qty[k]);
        e.price = o_price[k];
        e.pos   = 17'(m_pos[k]);
        e.sent  = 16'(m_sent[k]);
        e.busy  = offering[k] || (cyc < free_at[k]);
        return e;
    endfunction

    task automatic model(input int k, input bit r, input bit v, input logic [1:0] s,
                         input logic [31:0] p, input bit rdy);
        bit          is_beat;
        int          dec;
        int          eff;
        logic [31:0] effp;
        if (r) begin
            m_tgt[k] = 0; m_pos[k] = 0; m_sent[k] = 0; free_at[k] = 0;
            m_price[k] = 32'h0; offering[k] = 1'b0;
            o_side[k] = 1'b0; o_qty[k] = 0; o_price[k] = 32'h0;
            return;
        end
        is_beat = v && (s == 2'b01 || s == 2'b11);
        dec     = (s == 2'b01) ? LOT : -LOT;
        if (offering[k]) begin
            if (rdy) begin
                m_pos[k]    = o_side[k] ? m_pos[k] - o_qty[k] : m_pos[k] + o_qty[k];
                m_sent[k]   = (m_sent[k] + 1) % 65536;
                offering[k] = 1'b0;
                free_at[k]  = cyc + 1 + cd[k];
            end
        end else if (cyc >= free_at[k]) begin
            eff  = is_beat ? dec : m_tgt[k];
            effp = is_beat ? p : m_price[k];
            if (eff != m_pos[k]) begin
                offering[k] = 1'b1;
                o_side[k]   = (eff < m_pos[k]);
                o_qty[k]    = (eff > m_pos[k]) ? eff - m_pos[k] : m_pos[k] - eff;
                o_price[k]  = effp;
            end
        end
        if (is_beat) begin
            m_tgt[k]   = dec;
            m_price[k] = p;
        end
    endtask

    // One clock of stimulus: record what the DUTs should show this cycle, then drive and advance
    task automatic step(input bit r, input bit v, input logic [1:0] s,
                        input logic [31:0] p, input bit rdy);
        @(posedge clk);
        #1;
        if (started) begin
            q0.push_back(snapshot(0));
            q1.push_back(snapshot(1));
        end
        started   = 1'b1;
        rst       = r;
        in_valid  = v;
        in_signal = s;
        in_price  = p;
        ord_ready = rdy;
        for (int k = 0; k < 2; k++) model(k, r, v, s, p, rdy);
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'h0, rdy);
    endtask

    task automatic chk(input string name, input int k, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, c, act, exp);
        end
    endtask

    task automatic check(input int k, input exp_t e);
        chk("ord_valid", k, e.cyc, 32'(ov[k]), 32'(e.v));
        if (e.v) begin
            chk("ord_side",  k, e.cyc, 32'(os[k]), 32'(e.side));
            chk("ord_qty",   k, e.cyc, 32'(oq[k]), 32'(e.qty));
            chk("ord_price", k, e.cyc, op[k], e.price);
        end
        chk("position",    k, e.cyc, 32'(pos[k]),  32'(e.pos));
        chk("orders_sent", k, e.cyc, 32'(sent[k]), 32'(e.sent));
        chk("busy",        k, e.cyc, 32'(bsy[k]),  32'(e.busy));
    endtask

    // Monitor: compare each recorded expectation mid-cycle, away from the clock edge
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check(0, e0);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check(1, e1);
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_tgt[k] = 0; m_pos[k] = 0; m_sent[k] = 0; free_at[k] = 0;
            m_price[k] = 32'h0; offering[k] = 1'b0;
            o_side[k] = 1'b0; o_qty[k] = 0; o_price[k] = 32'h0;
        end

        // Reset, then HOLD and 2'b10 beats only: nothing should move
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, (i % 2 == 0) ? 2'b00 : 2'b10, $urandom, 1'(i % 2));

        // First BUY from flat, gateway ready
        step(1'b0, 1'b1, 2'b01, 32'h0064_0000, 1'b1);
        idle(20, 1'b1);

        // Reversal to short
        step(1'b0, 1'b1, 2'b11, 32'h0063_8000, 1'b1);
        idle(20, 1'b1);

        // Backpressure: BUY held off while SELL then BUY arrive
        step(1'b0, 1'b1, 2'b01, 32'h0062_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3)      step(1'b0, 1'b1, 2'b11, 32'h0061_0000, 1'b0);
            else if (i == 6) step(1'b0, 1'b1, 2'b01, 32'h0060_0000, 1'b0);
            else             step(1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
        end
        idle(25, 1'b1);

        // Cooldown: SELL accepted, then BUY three cycles after the accept
        step(1'b0, 1'b1, 2'b11, 32'h0070_0000, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 2'b01, 32'h0071_0000, 1'b1);
        idle(25, 1'b1);

        // Reset while an order is offered, then a fresh BUY
        step(1'b0, 1'b1, 2'b11, 32'h0072_0000, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 2'b01, 32'h0073_0000, 1'b1);
        idle(20, 1'b1);

        // Randomized traffic with occasional reset and bursty backpressure
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom),
                 $urandom,
                 ($urandom_range(0, 9) < 7));
        end

        idle(3, 1'b1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
